beat_tone_player: RTL and testbench
===================================

// Module: beat_tone_player
// PURPOSE
//  Consumes beat_en/beat_intensity from the accelerometer beat detector and plays a
//  fixed-length square-wave tone burst whose pitch follows the beat intensity.
//  After each burst a hold-off window blocks new beats so motion jitter cannot
//  machine-gun the speaker. audio_out drives the board speaker/PWM pin directly.
// PARAMETERS
//  CNT_W          24        width of all internal down-counters
//  HALF_PER_LO    56818     half-period in clk cycles, intensity 2'b00 (440 Hz @ 50 MHz)
//  HALF_PER_MID   37922     half-period, intensity 2'b01 (~659 Hz)
//  HALF_PER_HI    28409     half-period, intensity 2'b1x (880 Hz)
//  TONE_CYCLES    5000000   burst length in clk cycles (100 ms); must be >= 1
//  HOLDOFF_CYCLES 2500000   dead time after burst in clk cycles; must be >= 1
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active low
//  beat_en        in   1  beat detected (pulse or level from detector)
//  beat_intensity in   2  intensity code; 00 low, 01 mid, 10/11 high
//  mute           in   1  synchronous mute; forces audio_out low, timing unaffected
//  audio_out      out  1  square-wave tone output (registered)
//  playing        out  1  high while in PLAY
//  tone_sel       out  2  latched rank of current/last tone: 0 lo, 1 mid, 2 hi
//  beat_count     out  8  number of accepted triggers, wraps 255 -> 0
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; audio_out=0, playing=0, tone_sel=0,
//   beat_count=0, beat_en_d=0, all counters 0.
//  Trigger: trig = beat_en & ~beat_en_d; beat_en_d registers beat_en every cycle in
//   every state, so a level held through PLAY/HOLDOFF never produces a late trigger.
//  Rank: intensity 00 -> 0, 01 -> 1, 1x -> 2; HALF_PER selected by rank.
//  States: IDLE, PLAY, HOLDOFF (registered FSM).
//  IDLE: on trig at edge n -> PLAY; tone_sel<=rank; half_cnt<=HALF_PER(rank)-1;
//   dur_cnt<=TONE_CYCLES-1; audio_out<=0; playing<=1; beat_count+1. No trig: stay.
//  PLAY, each edge:
//   - half_cnt==0: toggle tone bit, reload HALF_PER(tone_sel)-1; else decrement.
//     First rising edge of audio_out is at edge n+HALF_PER.
//   - dur_cnt==0: -> HOLDOFF; playing<=0; audio_out<=0; hold_cnt<=HOLDOFF_CYCLES-1.
//     PLAY lasts exactly TONE_CYCLES cycles (playing high edges n..n+TONE_CYCLES).
//     Otherwise decrement dur_cnt.
//   - Retrigger: trig with rank strictly > tone_sel (and dur_cnt!=0): reload as in
//     IDLE (new tone_sel, phase reset to 0, full TONE_CYCLES), beat_count+1.
//     Rank <= tone_sel: ignored, not counted. Retrigger has priority over
//     half_cnt toggle. On the dur_cnt==0 edge the burst ends and trig is ignored.
//  HOLDOFF: trig ignored/not counted; hold_cnt==0 -> IDLE, else decrement.
//   Duration exactly HOLDOFF_CYCLES cycles. A trig on the HOLDOFF->IDLE edge is
//   ignored; first accepted trig is on the following edge.
//  audio_out = tone bit & ~mute, registered (mute takes effect one edge later);
//   tone bit keeps toggling while muted.
//  beat_count 8-bit modular; tone_sel holds its value through HOLDOFF/IDLE.
//  Reset mid-PLAY: immediate return to reset values; no burst resumes after release.
// TESTING (bench params: HALF_PER_LO=4, MID=3, HI=2, TONE_CYCLES=20, HOLDOFF_CYCLES=8)
//  1 Assert rst mid-run -> audio_out, playing, tone_sel, beat_count all 0 asynchronously.
//  2 1-cycle beat_en, intensity 00 at edge n -> playing 1 from n to n+20; audio_out
//    rises n+4, falls n+8, ...; 0 from n+20; beat_count=1, tone_sel=0.
//  3 beat_en held high 40 cycles, intensity 01 -> exactly one burst, beat_count=1,
//    no burst after HOLDOFF while still held.
//  4 trig 00 at n, trig 11 at n+6 -> half-period 2 from n+6, playing until n+26,
//    beat_count=2, tone_sel=2; trig 01 at n+10 ignored, count stays 2.
//  5 trig during HOLDOFF and on HOLDOFF->IDLE edge -> ignored; trig next edge -> new
//    burst; mute=1 during PLAY -> audio_out 0 one edge later, playing unaffected.
//  6 256 accepted beats from 0 -> beat_count wraps to 0.

Source files
------------

// File: rtl/beat_tone_player.sv
// Beat-triggered square-wave tone burst player with pitch ranked by beat intensity,
// fixed burst length and a hold-off window that blocks new beats after each burst.
module beat_tone_player #(
    parameter int CNT_W          = 24,
    parameter int HALF_PER_LO    = 56818,
    parameter int HALF_PER_MID   = 37922,
    parameter int HALF_PER_HI    = 28409,
    parameter int TONE_CYCLES    = 5000000,
    parameter int HOLDOFF_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beat_en_i,
    input  logic [1:0] beat_intensity_i,
    input  logic       mute_i,
    output logic       audio_out_o,
    output logic       playing_o,
    output logic [1:0] tone_sel_o,
    output logic [7:0] beat_count_o
);

    typedef enum logic [1:0] {IDLE, PLAY, HOLDOFF} state_e;

    state_e             state_q, state_d;
    logic               beatEnPrev_q;
    logic [1:0]         toneSel_q, toneSel_d;
    logic [CNT_W-1:0]   halfCnt_q, halfCnt_d;
    logic [CNT_W-1:0]   durCnt_q, durCnt_d;
    logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
    logic               toneBit_q, toneBit_d;
    logic               audio_q, audio_d;
    logic [7:0]         beatCount_q, beatCount_d;

    logic               trig;
    logic [1:0]         rank;

    function automatic logic [1:0] rankOf(input logic [1:0] code);
        if (code[1])      return 2'd2;
        else if (code[0]) return 2'd1;
        else              return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] halfReload(input logic [1:0] r);
        case (r)
            2'd0:    return CNT_W'(HALF_PER_LO - 1);
            2'd1:    return CNT_W'(HALF_PER_MID - 1);
            default: return CNT_W'(HALF_PER_HI - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beatEnPrev_q <= 1'b0;
            toneSel_q    <= 2'd0;
            halfCnt_q    <= '0;
            durCnt_q     <= '0;
            holdCnt_q    <= '0;
            toneBit_q    <= 1'b0;
            audio_q      <= 1'b0;
            beatCount_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            beatEnPrev_q <= beat_en_i;
            toneSel_q    <= toneSel_d;
            halfCnt_q    <= halfCnt_d;
            durCnt_q     <= durCnt_d;
            holdCnt_q    <= holdCnt_d;
            toneBit_q    <= toneBit_d;
            audio_q      <= audio_d;
            beatCount_q  <= beatCount_d;
        end
    end

    // Edge-detect on beat_en so a held level yields a single trigger.
    assign trig = beat_en_i & ~beatEnPrev_q;
    assign rank = rankOf(beat_intensity_i);

    always_comb begin
        state_d     = state_q;
        toneSel_d   = toneSel_q;
        halfCnt_d   = halfCnt_q;
        durCnt_d    = durCnt_q;
        holdCnt_d   = holdCnt_q;
        toneBit_d   = toneBit_q;
        beatCount_d = beatCount_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d     = PLAY;
                    toneSel_d   = rank;
                    halfCnt_d   = halfReload(rank);
                    durCnt_d    = CNT_W'(TONE_CYCLES - 1);
                    toneBit_d   = 1'b0;
                    beatCount_d = beatCount_q + 8'd1;
                end
            end
            PLAY: begin
                if (durCnt_q == '0) begin
                    state_d   = HOLDOFF;
                    holdCnt_d = CNT_W'(HOLDOFF_CYCLES - 1);
                    toneBit_d = 1'b0;
                end else if (trig && (rank > toneSel_q)) begin
                    // A stronger beat restarts the burst at the higher pitch.
                    toneSel_d   = rank;
                    halfCnt_d   = halfReload(rank);
                    durCnt_d    = CNT_W'(TONE_CYCLES - 1);
                    toneBit_d   = 1'b0;
                    beatCount_d = beatCount_q + 8'd1;
                end else begin
                    durCnt_d = durCnt_q - 1'b1;
                    if (halfCnt_q == '0) begin
                        toneBit_d = ~toneBit_q;
                        halfCnt_d = halfReload(toneSel_q);
                    end else begin
                        halfCnt_d = halfCnt_q - 1'b1;
                    end
                end
            end
            HOLDOFF: begin
                if (holdCnt_q == '0) state_d = IDLE;
                else                 holdCnt_d = holdCnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered from next-state values so the pin follows the tone bit on the same edge.
    always_comb begin
        audio_d      = (state_d == PLAY) ? (toneBit_d & ~mute_i) : 1'b0;
        audio_out_o  = audio_q;
        playing_o    = (state_q == PLAY);
        tone_sel_o   = toneSel_q;
        beat_count_o = beatCount_q;
    end

endmodule

// File: tb/tb_beat_tone_player.sv
// Self-checking bench for beat_tone_player: directed and random beats against a
// timeline model of bursts (start edge, end edge, first re-armed edge).
module tb_beat_tone_player;

    localparam int HP_LO = 4;
    localparam int HP_MID = 3;
    localparam int HP_HI = 2;
    localparam int TC = 20;
    localparam int HO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       beatEn = 1'b0;
    logic [1:0] intensity = 2'd0;
    logic       mute = 1'b0;
    logic       audioOut;
    logic       playing;
    logic [1:0] toneSel;
    logic [7:0] beatCount;

    int compareCount = 0;
    int mismatchCount = 0;

    // Reference model: burst timeline in edge numbers
    longint k = 0;
    longint burstStart = 0;
    longint playEnd = 0;
    longint idleFrom = 0;
    bit     burstValid = 1'b0;
    bit     prevEn = 1'b0;
    int     mRank = 0;
    int     mCount = 0;
    bit     expPlaying = 1'b0;
    bit     expAudio = 1'b0;

    always #5 clk = ~clk;

    beat_tone_player #(
        .CNT_W(24),
        .HALF_PER_LO(HP_LO),
        .HALF_PER_MID(HP_MID),
        .HALF_PER_HI(HP_HI),
        .TONE_CYCLES(TC),
        .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .beat_en_i(beatEn),
        .beat_intensity_i(intensity),
        .mute_i(mute),
        .audio_out_o(audioOut),
        .playing_o(playing),
        .tone_sel_o(toneSel),
        .beat_count_o(beatCount)
    );

    function automatic int rankOf(input logic [1:0] code);
        if (code == 2'b00) return 0;
        if (code == 2'b01) return 1;
        return 2;
    endfunction

    function automatic int halfPer(input int r);
        if (r == 0) return HP_LO;
        if (r == 1) return HP_MID;
        return HP_HI;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            mismatchCount++;
            $error("[TB] FAIL %s at edge %0d: observed %0d, expected %0d", tag, k, observed, expected);
        end
    endtask

    task automatic resetModel();
        burstValid = 1'b0;
        prevEn = 1'b0;
        mRank = 0;
        mCount = 0;
        idleFrom = k;
        expPlaying = 1'b0;
        expAudio = 1'b0;
    endtask

    task automatic startBurst(input int r);
        burstValid = 1'b1;
        burstStart = k;
        playEnd = k + TC;
        idleFrom = playEnd + HO + 1;
        mRank = r;
        mCount = (mCount + 1) % 256;
    endtask

    task automatic modelEdge(input logic en, input logic [1:0] inten, input logic mu);
        bit trig;
        int r;
        longint t;
        trig = en && !prevEn;
        r = rankOf(inten);
        if (trig && k >= idleFrom)
            startBurst(r);
        else if (trig && burstValid && k > burstStart && k < playEnd && r > mRank)
            startBurst(r);
        prevEn = en;
        expPlaying = burstValid && k >= burstStart && k < playEnd;
        if (expPlaying) begin
            t = k - burstStart;
            expAudio = (((t / halfPer(mRank)) % 2) == 1) && !mu;
        end else begin
            expAudio = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".playing"}, {7'd0, playing}, {7'd0, expPlaying});
        checkOutput({tag, ".audio"}, {7'd0, audioOut}, {7'd0, expAudio});
        checkOutput({tag, ".toneSel"}, {6'd0, toneSel}, 8'(mRank));
        checkOutput({tag, ".count"}, beatCount, 8'(mCount));
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] inten, input logic mu, input string tag);
        @(negedge clk);
        beatEn = en;
        intensity = inten;
        mute = mu;
        @(posedge clk);
        #1;
        k++;
        modelEdge(en, inten, mu);
        checkAll(tag);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic asyncReset(input string tag);
        @(negedge clk);
        beatEn = 1'b0;
        mute = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        resetModel();
        checkAll(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        #3;
        resetModel();
        checkAll("reset0");
        @(negedge clk);
        rst = 1'b1;

        // Single low-intensity pulse, full burst and hold-off
        applyStimulus(1'b1, 2'b00, 1'b0, "pulseLo");
        for (int i = 1; i < 32; i++) applyStimulus(1'b0, 2'b00, 1'b0, "pulseLo");

        // Level held for 40 cycles yields exactly one burst
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 2'b01, 1'b0, "heldMid");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b01, 1'b0, "heldMid");

        // Retrigger to high at +6, lower-rank retrigger at +10 ignored
        for (int i = 0; i < 36; i++)
            applyStimulus(i == 0 || i == 6 || i == 10,
                          (i == 6) ? 2'b11 : ((i == 10) ? 2'b01 : 2'b00), 1'b0, "retrig");
        checkOutput("retrigCount", beatCount, 8'(mCount));

        // Beats in hold-off and on the re-arm edge ignored, mute mid-burst
        for (int i = 0; i < 50; i++)
            applyStimulus(i == 0 || i == 25 || i == 28 || i == 30, 2'b00,
                          i >= 5 && i < 12, "holdoffMute");

        // Mid-burst asynchronous reset, then no burst resumes
        applyStimulus(1'b1, 2'b10, 1'b0, "midReset");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b10, 1'b0, "midReset");
        asyncReset("asyncRst");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b00, 1'b0, "postReset");

        // 256 accepted beats wrap the counter back to 0
        for (int b = 0; b < 256; b++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, "wrap");
            for (int i = 0; i < 28; i++)
                applyStimulus(1'b0, 2'b00, $urandom_range(0, 7) == 0, "wrap");
        end
        checkOutput("wrapCount", beatCount, 8'd0);

        // Random beats, intensities and mute
        for (int i = 0; i < 800; i++)
            applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 7) == 0, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
